tinsel_msg_redirect_accel: RTL and testbench

TINSEL_MSG_REDIRECT_ACCEL -- requirements
Module: tinsel_msg_redirect_accel

---
 rtl/tinsel_msg_redirect_accel.sv | 88 ++++++++
 tb/tb_tinsel_msg_redirect_accel.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tinsel_msg_redirect_accel.sv
// tinsel_msg_redirect_accel: re-addresses each message to the destination carried in its head flit payload
module tinsel_msg_redirect_accel #(
  parameter int TILE_X      = 0,
  parameter int TILE_Y      = 0,
  parameter int FIFO_DEPTH  = 4,
  parameter int DROP_IDLE   = 0,
  parameter int MESH_X_BITS = 3,
  parameter int MESH_Y_BITS = 3,
  parameter int ADDR_BITS   = 16,
  parameter int FLIT_BITS   = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [MESH_X_BITS-1:0]            board_x,
  input  logic [MESH_Y_BITS-1:0]            board_y,
  input  logic [ADDR_BITS+FLIT_BITS+1:0]    in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [ADDR_BITS+FLIT_BITS+1:0]    out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [31:0]                       msg_count,
  output logic                              busy
);
  localparam int FW = ADDR_BITS + FLIT_BITS + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = FIFO_DEPTH[CW-1:0];

  typedef enum logic {HEAD, BODY} state_t;

  state_t               r_state;
  logic [FW-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr, r_rd;
  logic [CW-1:0]        r_cnt;
  logic [FW-1:0]        r_out;
  logic                 r_ov;
  logic [ADDR_BITS-1:0] r_dest;
  logic [31:0]          r_msgs;

  logic [FW-1:0]        w_h, w_xf;
  logic [FLIT_BITS-1:0] w_pl;
  logic                 w_push, w_pop, w_load, w_hs, w_idle, w_nf, w_unused;

  assign w_unused  = ^{board_x, board_y, TILE_X[0], TILE_Y[0]};
  assign w_h       = r_mem[r_rd];
  assign w_pl      = w_h[FLIT_BITS+1:2];
  assign w_nf      = w_h[1];
  // Idle tokens only mean anything between messages; inside a message they are data.
  assign w_idle    = w_h[0] && (r_state == HEAD);
  assign in_ready  = r_cnt < DEPTH;
  assign w_push    = in_valid && in_ready;
  assign w_hs      = r_ov && out_ready;
  assign w_pop     = (r_cnt != '0) && (!r_ov || out_ready);
  assign w_load    = w_pop && !(w_idle && DROP_IDLE != 0);
  assign w_xf      = w_idle ? w_h
                   : {(r_state == BODY) ? r_dest : w_pl[ADDR_BITS-1:0], w_pl, w_nf, 1'b0};
  assign out_data  = r_out;
  assign out_valid = r_ov;
  assign msg_count = r_msgs;
  assign busy      = (r_cnt != '0) || r_ov || (r_state == BODY);

  always_ff @(negedge clk)
    if (w_push) r_mem[r_wr] <= in_data;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_ov    <= 1'b0;
      r_state <= HEAD;
      r_dest  <= '0;
      r_msgs  <= '0;
    end else begin
      r_wr  <= r_wr + AW'(w_push);
      r_rd  <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_ov  <= w_load || (r_ov && !out_ready);
      if (w_load) r_out <= w_xf;
      if (w_hs && !r_out[1] && !r_out[0]) r_msgs <= r_msgs + 32'd1;
      if (w_pop && !w_idle) begin
        r_state <= w_nf ? BODY : HEAD;
        if (r_state == HEAD) r_dest <= w_pl[ADDR_BITS-1:0];
      end
    end
  end
endmodule

// File: tb/tb_tinsel_msg_redirect_accel.sv
// tb_tinsel_msg_redirect_accel: directed checks of destination redirection, flow control, idle handling and reset
module tb_tinsel_msg_redirect_accel;
  localparam int AW = 16, PW = 64, FW = AW + PW + 2, DEPTH = 4;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [FW-1:0] in_data = '0;
  logic [2:0]    board_x = 3'd1, board_y = 3'd2;
  logic          in_ready, out_valid, busy, in_ready_d, out_valid_d, busy_d;
  logic [FW-1:0] out_data, out_data_d;
  logic [31:0]   msg_count, msg_count_d;

  int            n_checks = 0, n_errors = 0, cyc = 0, n_out_d = 0;
  logic [FW-1:0] exp_q[$], exp_qd[$];
  logic [FW-1:0] last_out = '0, prev_data = '0, e_m, e_md;
  bit            prev_stall = 0, m_body = 0;
  logic [AW-1:0] m_dest = '0;

  tinsel_msg_redirect_accel #(.FIFO_DEPTH(DEPTH), .DROP_IDLE(0)) dut (
    .clk(clk), .rst_n(rst_n), .board_x(board_x), .board_y(board_y),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .msg_count(msg_count), .busy(busy));

  tinsel_msg_redirect_accel #(.FIFO_DEPTH(DEPTH), .DROP_IDLE(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .board_x(board_x), .board_y(board_y),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_d),
    .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready),
    .msg_count(msg_count_d), .busy(busy_d));

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [AW-1:0] d, input logic [PW-1:0] p,
                                       input logic nf, input logic idle);
    return {d, p, nf, idle};
  endfunction

  // Reference behaviour: what each DUT should emit for an accepted flit.
  task automatic model(input logic [FW-1:0] f);
    logic [PW-1:0] p;
    logic [FW-1:0] e;
    p = f[PW+1:2];
    if (m_body) begin
      e = {m_dest, p, f[1], 1'b0};
      exp_q.push_back(e);
      exp_qd.push_back(e);
      m_body = f[1];
    end else if (f[0]) begin
      exp_q.push_back(f);
    end else begin
      m_dest = p[AW-1:0];
      e = {m_dest, p, f[1], 1'b0};
      exp_q.push_back(e);
      exp_qd.push_back(e);
      m_body = f[1];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [FW-1:0] f);
    int n = 0;
    in_data = f;
    in_valid = 1'b1;
    @(posedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(posedge clk);
    end
    if (n == 200) check("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    #1;
    model(f);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_qd.size() != 0 || busy || busy_d) && n < 100) begin
      tick(1);
      n++;
    end
    check("drain_left", exp_q.size() + exp_qd.size(), 0);
  endtask

  always @(posedge clk) begin
    if (rst_n && prev_stall) check("out_hold", out_data, prev_data);
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    if (rst_n && out_valid && out_ready) begin
      e_m = exp_q.size() != 0 ? exp_q.pop_front() : {FW{1'bx}};
      check("out_flit", out_data, e_m);
      last_out = out_data;
    end
    if (rst_n && out_valid_d && out_ready) begin
      e_md = exp_qd.size() != 0 ? exp_qd.pop_front() : {FW{1'bx}};
      check("outd_flit", out_data_d, e_md);
      n_out_d++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, total, len, nd;
    logic [AW-1:0] d;
    logic [PW-1:0] p;
    tick(3);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_msg_count", msg_count, 0);
    check("rst_outd_valid", out_valid_d, 0);
    rst_n = 1'b1;
    tick(1);

    send(mk(16'h0F0F, 64'h1111_2222_3333_0123, 1'b0, 1'b0));
    check("lat_n", out_valid, 0);
    tick(1);
    check("lat_n1", out_valid, 1);
    check("single_dest", out_data[FW-1 -: AW], 16'h0123);
    drain();
    check("single_msgs", msg_count, 1);
    check("single_busy", busy, 0);

    send(mk(16'h0001, 64'hAAAA_0000_0000_0045, 1'b1, 1'b0));
    send(mk(16'h0002, 64'hBBBB_0000_0000_07FF, 1'b1, 1'b0));
    send(mk(16'h0003, 64'hCCCC_0000_0000_07FF, 1'b0, 1'b0));
    drain();
    check("msg3_last_dest", last_out[FW-1 -: AW], 16'h0045);
    check("msg3_last_nf", last_out[1], 0);
    check("msg3_msgs", msg_count, 2);

    nd = n_out_d;
    send(mk(16'h0ABC, 64'hDEAD_BEEF_0000_0777, 1'b0, 1'b1));
    drain();
    check("idle_fwd", last_out, mk(16'h0ABC, 64'hDEAD_BEEF_0000_0777, 1'b0, 1'b1));
    check("idle_msgs", msg_count, 2);
    check("idle_drop_outs", n_out_d, nd);
    check("idle_drop_msgs", msg_count_d, 2);

    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send(mk(16'h0100, {48'h5A5A_0000_0000, 16'h0200 + 16'(i)}, 1'b0, 1'b0));
    tick(1);
    check("full_in_ready", in_ready, 0);
    check("full_out_valid", out_valid, 1);
    check("full_head_dest", out_data[FW-1 -: AW], 16'h0200);
    tick(3);
    check("full_stable", out_data[FW-1 -: AW], 16'h0200);
    out_ready = 1'b1;
    drain();
    check("full_msgs", msg_count, 7);
    check("full_msgs_d", msg_count_d, 7);

    send(mk(16'h0000, 64'h0000_0000_0000_0333, 1'b1, 1'b0));
    send(mk(16'h0000, 64'h0000_0000_0000_0444, 1'b1, 1'b0));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_q.delete();
    exp_qd.delete();
    m_body = 0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_msgs", msg_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    send(mk(16'h0777, 64'h0000_0000_0000_0010, 1'b0, 1'b0));
    drain();
    check("post_rst_dest", last_out[FW-1 -: AW], 16'h0010);
    check("post_rst_msgs", msg_count, 1);

    c0 = cyc;
    total = 0;
    for (int m = 0; m < 100; m++) begin
      len = $urandom_range(1, 3);
      d = 16'($urandom);
      for (int j = 0; j < len; j++) begin
        p = {$urandom, $urandom};
        if (j == 0) p[AW-1:0] = d;
        send(mk(16'($urandom), p, j < len - 1, 1'b0));
        total++;
      end
    end
    check("throughput_cycles", cyc - c0, total);
    drain();
    check("rand_msgs", msg_count, 101);
    check("rand_msgs_d", msg_count_d, 101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
